// File: rtl/eeprom_key_pkg.sv
// Shared types and helpers for the EEPROM key-loading sequencers.
package eeprom_key_pkg;

    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        NEXT,
        DONE,
        ERR
    } state_e;

    // Counter width able to hold 0 .. cycles-1.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/eeprom_byte_timer.sv
// Per-byte watchdog: restarts on start, counts while run, flags the last allowed cycle.
module eeprom_byte_timer
    import eeprom_key_pkg::*;
#(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic expire_c
);

    localparam int unsigned W = timer_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q;

    // Saturates at LAST so a stalled owner never sees the count wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (run && (count_q != LAST)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expire_c = run && (count_q == LAST);

endmodule

// File: rtl/eeprom_key_loader.sv
// Reads KEY_BYTES bytes from the AT25010 byte interface into a flat key register.
// Define EEPROM_KEY_CHECKSUM_EN to read and verify a trailing XOR checksum byte.
module eeprom_key_loader
    import eeprom_key_pkg::*;
#(
    parameter int unsigned KEY_BYTES      = 16,
    parameter logic [7:0]  BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    output logic                   loading,
    output logic [8*KEY_BYTES-1:0] key,
    output logic                   key_valid,
    output logic                   key_err,
    output logic                   rd_req,
    output logic [7:0]             rd_addr,
    input  logic [7:0]             rd_data,
    input  logic                   rd_valid,
    input  logic                   rd_busy
);

    localparam int unsigned KEY_W = 8 * KEY_BYTES;
`ifdef EEPROM_KEY_CHECKSUM_EN
    localparam int unsigned NUM_READS = KEY_BYTES + 1;
    localparam logic [7:0]  KEY_LAST  = 8'(KEY_BYTES - 1);
`else
    localparam int unsigned NUM_READS = KEY_BYTES;
`endif
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_READS - 1);

    state_e             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_valid_q, key_valid_d;
    logic               key_err_q, key_err_d;
    logic               loading_q, loading_d;
    logic               rd_req_q, rd_req_d;
    logic [7:0]         rd_addr_q, rd_addr_d;
    logic               timer_start_c;
    logic               timer_expire_c;
`ifdef EEPROM_KEY_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
    logic               csum_ok_q, csum_ok_d;
`endif

    eeprom_byte_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (timer_start_c),
        .run      (state_q == WAIT),
        .expire_c (timer_expire_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            loading_q   <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= BASE_ADDR;
`ifdef EEPROM_KEY_CHECKSUM_EN
            xor_q       <= '0;
            csum_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            loading_q   <= loading_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
`ifdef EEPROM_KEY_CHECKSUM_EN
            xor_q       <= xor_d;
            csum_ok_q   <= csum_ok_d;
`endif
        end
    end

    // Next-state logic; outputs are registered from the state being entered.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        key_d         = key_q;
        key_valid_d   = key_valid_q;
        key_err_d     = key_err_q;
        loading_d     = loading_q;
        rd_req_d      = 1'b0;
        rd_addr_d     = rd_addr_q;
        timer_start_c = 1'b0;
`ifdef EEPROM_KEY_CHECKSUM_EN
        xor_d         = xor_q;
        csum_ok_d     = csum_ok_q;
`endif

        case (state_q)
            IDLE: begin
                if (load) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    key_err_d   = 1'b0;
                    idx_d       = '0;
                    loading_d   = 1'b1;
`ifdef EEPROM_KEY_CHECKSUM_EN
                    xor_d       = '0;
                    csum_ok_d   = 1'b0;
`endif
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (!rd_busy) begin
                    rd_req_d      = 1'b1;
                    rd_addr_d     = BASE_ADDR + idx_q;
                    timer_start_c = 1'b1;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // A strobe on the final allowed cycle still counts as a capture.
                if (rd_valid) begin
`ifdef EEPROM_KEY_CHECKSUM_EN
                    if (idx_q > KEY_LAST) begin
                        csum_ok_d = (rd_data == xor_q);
                    end else begin
                        xor_d = xor_q ^ rd_data;
                    end
`endif
                    for (int i = 0; i < KEY_BYTES; i++) begin
                        if (idx_q == 8'(i)) begin
                            key_d[8*i +: 8] = rd_data;
                        end
                    end
                    state_d = NEXT;
                end else if (timer_expire_c) begin
                    state_d = ERR;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
`ifdef EEPROM_KEY_CHECKSUM_EN
                    state_d = csum_ok_q ? DONE : ERR;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Completion flags take effect on entry to the terminal state.
        if (state_d != state_q) begin
            if (state_d == DONE) begin
                key_valid_d = 1'b1;
                loading_d   = 1'b0;
            end else if (state_d == ERR) begin
                key_d       = '0;
                key_err_d   = 1'b1;
                key_valid_d = 1'b0;
                loading_d   = 1'b0;
            end
        end
    end

    assign loading   = loading_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_eeprom_key_loader.sv
// Directed bench for eeprom_key_loader with a small byte-interface model (fixed latency).
module tb_eeprom_key_loader;

`ifdef EEPROM_KEY_CHECKSUM_EN
    localparam int unsigned NUM_READS = 5;
`else
    localparam int unsigned NUM_READS = 4;
`endif
    localparam int unsigned LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        loading;
    logic [31:0] key;
    logic        key_valid;
    logic        key_err;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_busy;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    logic [7:0]  mem [256];
    logic        drop_en;
    logic [7:0]  drop_addr;
    logic [7:0]  req_cnt;
    logic [7:0]  addr_log [8];
    int unsigned pend;
    logic [7:0]  pend_addr;

    eeprom_key_loader #(
        .KEY_BYTES      (4),
        .BASE_ADDR      (8'hFE),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .loading   (loading),
        .key       (key),
        .key_valid (key_valid),
        .key_err   (key_err),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_busy   (rd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-interface model: answers each request LAT+1 cycles later unless dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            req_cnt  <= 8'd0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_req) begin
                addr_log[req_cnt[2:0]] <= rd_addr;
                req_cnt <= req_cnt + 8'd1;
                if (drop_en && rd_addr == drop_addr) begin
                    pend <= 0;
                end else begin
                    pend      <= LAT;
                    pend_addr <= rd_addr;
                end
            end else if (pend != 0) begin
                pend <= pend - 1;
                if (pend == 1) begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[pend_addr];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (loading && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(loading), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_loading"}, 32'(loading), 32'd0);
        check({tag, "_key"}, key, 32'h0);
        check({tag, "_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_err"}, 32'(key_err), 32'd0);
        check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'h0000_00FE);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  base;
        int unsigned n;
        int unsigned seen;

        rst_n     = 1'b0;
        load      = 1'b0;
        rd_busy   = 1'b0;
        drop_en   = 1'b0;
        drop_addr = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = 8'(8'hA0 + a);
        // XOR of 9E,9F,A0,A1 is 00, so a trailing checksum byte at 02 must be 00.
        mem[8'h02] = 8'h00;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Normal load with address wrap FE,FF,00,01.
        base = req_cnt;
        pulse_load();
        check("loading_rises", 32'(loading), 32'd1);
        wait_idle("norm_finish");
        check("norm_key", key, 32'hA1A0_9F9E);
        check("norm_valid", 32'(key_valid), 32'd1);
        check("norm_err", 32'(key_err), 32'd0);
        check("norm_reqs", 32'(8'(req_cnt - base)), NUM_READS);
        check("norm_addr0", 32'(addr_log[base[2:0]]), 32'hFE);
        check("norm_addr1", 32'(addr_log[3'(base + 8'd1)]), 32'hFF);
        check("norm_addr2", 32'(addr_log[3'(base + 8'd2)]), 32'h00);
        check("norm_addr3", 32'(addr_log[3'(base + 8'd3)]), 32'h01);

        // Timeout on byte 2 (address 00).
        drop_en   = 1'b1;
        drop_addr = 8'h00;
        base      = req_cnt;
        pulse_load();
        check("reload_clears_valid", 32'(key_valid), 32'd0);
        n = 0;
        while (!(rd_req && rd_addr == 8'h00) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_req_seen", 32'(rd_req && rd_addr == 8'h00), 32'd1);
        n = 0;
        while (!key_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", n, 32'd16);
        check("to_err", 32'(key_err), 32'd1);
        check("to_key", key, 32'h0);
        check("to_valid", 32'(key_valid), 32'd0);
        check("to_loading", 32'(loading), 32'd0);
        repeat (3) @(negedge clk);
        check("to_reqs", 32'(8'(req_cnt - base)), 32'd3);
        drop_en = 1'b0;
        pulse_load();
        check("retry_err_cleared", 32'(key_err), 32'd0);
        wait_idle("retry_finish");
        check("retry_key", key, 32'hA1A0_9F9E);
        check("retry_valid", 32'(key_valid), 32'd1);

        // Busy at start and a second load mid-sequence.
        rd_busy = 1'b1;
        base    = req_cnt;
        pulse_load();
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_req) seen++;
        end
        check("busy_no_req", seen, 32'd0);
        rd_busy = 1'b0;
        n = 0;
        while (8'(req_cnt - base) < 8'd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        pulse_load();
        wait_idle("busy_finish");
        repeat (8) @(negedge clk);
        check("busy_reqs", 32'(8'(req_cnt - base)), NUM_READS);
        check("busy_key", key, 32'hA1A0_9F9E);
        check("busy_valid", 32'(key_valid), 32'd1);

        // Reset after byte 1 captured.
        pulse_load();
        seen = 0;
        n    = 0;
        while (seen < 2 && n < 100) begin
            @(negedge clk);
            if (rd_valid) seen++;
            n++;
        end
        @(negedge clk);
        check("mid_partial_key", key, 32'h0000_9F9E);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_load();
        wait_idle("fresh_finish");
        check("fresh_key", key, 32'hA1A0_9F9E);
        check("fresh_valid", 32'(key_valid), 32'd1);

        // Checksum: bytes 01..04, checksum 04 then 05.
        mem[8'hFE] = 8'h01;
        mem[8'hFF] = 8'h02;
        mem[8'h00] = 8'h03;
        mem[8'h01] = 8'h04;
        mem[8'h02] = 8'h04;
        pulse_load();
        wait_idle("cs_good_finish");
        check("cs_good_key", key, 32'h0403_0201);
        check("cs_good_valid", 32'(key_valid), 32'd1);
        check("cs_good_err", 32'(key_err), 32'd0);
        mem[8'h02] = 8'h05;
        base = req_cnt;
        pulse_load();
        wait_idle("cs_bad_finish");
        check("cs_bad_reqs", 32'(8'(req_cnt - base)), NUM_READS);
`ifdef EEPROM_KEY_CHECKSUM_EN
        check("cs_bad_key", key, 32'h0);
        check("cs_bad_valid", 32'(key_valid), 32'd0);
        check("cs_bad_err", 32'(key_err), 32'd1);
`else
        check("cs_bad_key", key, 32'h0403_0201);
        check("cs_bad_valid", 32'(key_valid), 32'd1);
        check("cs_bad_err", 32'(key_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
